// File: rtl/signal_mixer_seq_if.sv
// signal_mixer_seq_if -- bus between the voice generators / control logic
// (master side) and the time-multiplexed mixer (slave side).
//
// Signals (direction seen from the mixer):
//   sample_strobe  in   one-cycle pulse that starts a mix
//   samples_in     in   packed unsigned samples, channel i at [i*SAMPLE_W +: SAMPLE_W]
//   sample_enable  in   per-channel enable
//   gain           in   packed per-channel gain, unity = 2^(GAIN_W-1)
//   saturate       in   1 = clamp the output, 0 = wrap
//   clear_overrun  in   clears the sticky overrun flag
//   sample_out     out  mixed sample, held until the next result
//   out_valid      out  one-cycle pulse when sample_out updates
//   busy           out  mix in progress
//   active_count   out  enabled channels in the last completed mix
//   overrun        out  sticky: a strobe arrived while busy
interface signal_mixer_seq_if #(
  parameter int NUM_CH   = 12,
  parameter int SAMPLE_W = 8,
  parameter int GAIN_W   = 4
);
  localparam int CNT_W = $clog2(NUM_CH + 1);

  logic                         sample_strobe;
  logic [NUM_CH*SAMPLE_W-1:0]   samples_in;
  logic [NUM_CH-1:0]            sample_enable;
  logic [NUM_CH*GAIN_W-1:0]     gain;
  logic                         saturate;
  logic                         clear_overrun;
  logic [SAMPLE_W-1:0]          sample_out;
  logic                         out_valid;
  logic                         busy;
  logic [CNT_W-1:0]             active_count;
  logic                         overrun;

  modport master (
    output sample_strobe, samples_in, sample_enable, gain, saturate, clear_overrun,
    input  sample_out, out_valid, busy, active_count, overrun
  );

  modport slave (
    input  sample_strobe, samples_in, sample_enable, gain, saturate, clear_overrun,
    output sample_out, out_valid, busy, active_count, overrun
  );
endinterface

// File: rtl/signal_mixer_seq.sv
// signal_mixer_seq -- time-multiplexed audio mixer.
//
// Sums NUM_CH unsigned samples, each scaled by its own gain, into one output
// sample. A sample_strobe latches all inputs into shadow registers, then one
// channel per clock goes through a single multiply-accumulate. The final sum
// is scaled back by the unity-gain shift plus OUT_SHIFT and either wrapped or
// saturated to SAMPLE_W bits.
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous, active-high reset
//   bus  signal_mixer_seq_if.slave (strobe, samples, enables, gains, mode,
//        overrun clear in; sample_out, out_valid, busy, active_count,
//        overrun out)
//
// Latency: strobe sampled at edge E -> out_valid visible after edge
// E+NUM_CH+1; one mix every NUM_CH+2 cycles, back-to-back allowed.
module signal_mixer_seq #(
  parameter int NUM_CH    = 12,
  parameter int SAMPLE_W  = 8,
  parameter int GAIN_W    = 4,
  parameter int OUT_SHIFT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  signal_mixer_seq_if.slave    bus
);

  localparam int IDX_W  = $clog2(NUM_CH);
  localparam int CNT_W  = $clog2(NUM_CH + 1);
  localparam int PROD_W = SAMPLE_W + GAIN_W;
  localparam int ACC_W  = SAMPLE_W + GAIN_W + $clog2(NUM_CH);
  localparam int SHIFT  = GAIN_W - 1 + OUT_SHIFT;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;

  // Final scaling: anything above the SAMPLE_W range is either dropped
  // (wrap) or clamped to full scale (saturate).
  function automatic logic [SAMPLE_W-1:0] out_sat(input logic [ACC_W-1:0] r,
                                                  input logic sat);
    if (sat && (|r[ACC_W-1:SAMPLE_W]))
      return '1;
    else
      return r[SAMPLE_W-1:0];
  endfunction

  // Stage p0: shadow copies of the mix inputs, captured on an accepted strobe
  logic [SAMPLE_W-1:0] smp_p0 [NUM_CH];
  logic [GAIN_W-1:0]   gn_p0  [NUM_CH];
  logic [NUM_CH-1:0]   en_p0;
  logic                sat_p0;

  logic accept;
  assign accept = (state == IDLE) && bus.sample_strobe;

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        smp_p0[i] <= bus.samples_in[i*SAMPLE_W +: SAMPLE_W];
        gn_p0[i]  <= bus.gain[i*GAIN_W +: GAIN_W];
      end
      en_p0  <= bus.sample_enable;
      sat_p0 <= bus.saturate;
    end
  end

  // Stage p1: multiply-accumulate on the channel selected by idx
  logic [IDX_W-1:0]  idx;
  logic [CNT_W-1:0]  cnt;
  logic [ACC_W-1:0]  acc;
  logic [PROD_W-1:0] prod;

  always_comb begin
    prod = '0;
    prod = PROD_W'(smp_p0[idx]) * PROD_W'(gn_p0[idx]);
  end

  // Stage p2: registered outputs
  logic [SAMPLE_W-1:0] sample_out_r;
  logic                out_valid_r;
  logic                busy_r;
  logic [CNT_W-1:0]    active_count_r;
  logic                overrun_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      idx            <= '0;
      cnt            <= '0;
      sample_out_r   <= '0;
      out_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
      active_count_r <= '0;
      overrun_r      <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;

      // Written after the clear so that a same-cycle overrun event wins.
      if (bus.clear_overrun)
        overrun_r <= 1'b0;
      if (bus.sample_strobe && (state != IDLE))
        overrun_r <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.sample_strobe) begin
            acc    <= '0;
            idx    <= '0;
            cnt    <= '0;
            busy_r <= 1'b1;
            state  <= ACCUM;
          end
        end

        ACCUM: begin
          if (en_p0[idx]) begin
            acc <= acc + ACC_W'(prod);
            cnt <= cnt + CNT_W'(1);
          end
          if (idx == LAST_IDX) begin
            // Park idx at 0 so the array lookup stays in range during DONE.
            idx   <= '0;
            state <= DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        DONE: begin
          sample_out_r   <= out_sat(acc >> SHIFT, sat_p0);
          active_count_r <= cnt;
          out_valid_r    <= 1'b1;
          busy_r         <= 1'b0;
          state          <= IDLE;
        end

        default: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign bus.sample_out   = sample_out_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.busy         = busy_r;
  assign bus.active_count = active_count_r;
  assign bus.overrun      = overrun_r;

endmodule

// File: tb/tb_signal_mixer_seq.sv
// Directed testbench for signal_mixer_seq with hand-computed expected values.
module tb_signal_mixer_seq;

  localparam int NUM_CH   = 12;
  localparam int SAMPLE_W = 8;
  localparam int GAIN_W   = 4;
  localparam int LAT      = NUM_CH + 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  signal_mixer_seq_if #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W)) bus ();

  signal_mixer_seq #(
    .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .GAIN_W(GAIN_W), .OUT_SHIFT(0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Same sample/gain on every channel, enable mask as given.
  task automatic set_all(input int s, input int g, input logic [NUM_CH-1:0] en);
    for (int i = 0; i < NUM_CH; i++) begin
      bus.samples_in[i*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(s);
      bus.gain[i*GAIN_W +: GAIN_W]           = GAIN_W'(g);
    end
    bus.sample_enable = en;
  endtask

  // Strobe sampled at the next edge E; returns #1 after E with strobe low.
  task automatic strobe();
    bus.sample_strobe = 1'b1;
    @(posedge clk); #1;
    bus.sample_strobe = 1'b0;
  endtask

  // Edges until out_valid seen (checked #1 after each edge); -1 on timeout.
  task automatic wait_valid(output int n);
    n = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic full_mix(input string tag, input int exp_out, input int exp_cnt);
    int n;
    strobe();
    chk({tag, ".busy"}, bus.busy, 1);
    wait_valid(n);
    chk({tag, ".lat"}, n, LAT);
    chk({tag, ".out"}, bus.sample_out, exp_out);
    chk({tag, ".cnt"}, bus.active_count, exp_cnt);
    @(posedge clk); #1;
    chk({tag, ".vld_lo"}, bus.out_valid, 0);
    chk({tag, ".busy_lo"}, bus.busy, 0);
  endtask

  initial begin
    int n;
    int seen;
    rst = 1'b1;
    bus.sample_strobe = 1'b0;
    bus.saturate      = 1'b0;
    bus.clear_overrun = 1'b0;
    set_all(0, 0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.out", bus.sample_out, 0);
    chk("rst.vld", bus.out_valid, 0);
    chk("rst.busy", bus.busy, 0);
    chk("rst.cnt", bus.active_count, 0);
    chk("rst.ovr", bus.overrun, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Unity gain, 12 x 20 = 240
    set_all(20, 8, '1);
    full_mix("unity20", 240, 12);

    // 1200 wraps to 176, clamps to 255
    set_all(100, 8, '1);
    full_mix("wrap100", 176, 12);
    bus.saturate = 1'b1;
    full_mix("sat100", 255, 12);
    bus.saturate = 1'b0;

    // Only ch0 enabled; disabled channels at full scale must not contribute
    set_all(255, 15, 12'h001);
    bus.samples_in[0 +: SAMPLE_W] = 8'd200;
    bus.gain[0 +: GAIN_W]         = 4'd4;
    full_mix("gain4", 100, 1);
    bus.samples_in[0 +: SAMPLE_W] = 8'd100;
    bus.gain[0 +: GAIN_W]         = 4'd15;
    full_mix("gain15", 187, 1);

    // Overrun: second strobe 3 cycles in, plus input change during the mix
    set_all(20, 8, '1);
    strobe();                                 // edge E
    set_all(100, 15, 12'h00F);                // must not affect the mix
    @(posedge clk); #1;                       // E+1
    @(posedge clk); #1;                       // E+2
    strobe();                                 // E+3, ignored
    chk("ovr.set", bus.overrun, 1);
    chk("ovr.busy", bus.busy, 1);
    wait_valid(n);
    chk("ovr.lat", n, LAT - 3);
    chk("ovr.out", bus.sample_out, 240);
    chk("ovr.cnt", bus.active_count, 12);
    bus.clear_overrun = 1'b1;
    @(posedge clk); #1;
    bus.clear_overrun = 1'b0;
    chk("ovr.clr", bus.overrun, 0);
    // Clear and ignored strobe together: set wins
    set_all(20, 8, '1);
    strobe();
    @(posedge clk); #1;
    bus.clear_overrun = 1'b1;
    strobe();
    bus.clear_overrun = 1'b0;
    chk("ovr.setwins", bus.overrun, 1);
    wait_valid(n);
    chk("ovr2.out", bus.sample_out, 240);

    // Reset at the 5th ACCUM cycle aborts the mix
    set_all(10, 8, '1);
    strobe();                                 // E
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;                       // E+5 samples reset
    rst = 1'b0;
    chk("abort.busy", bus.busy, 0);
    chk("abort.out", bus.sample_out, 0);
    chk("abort.ovr", bus.overrun, 0);
    seen = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("abort.novld", seen, 0);
    full_mix("after_abort", 120, 12);

    // Back-to-back: strobe in the out_valid cycle, second mix with no enables
    set_all(100, 8, '1);
    strobe();
    set_all(100, 8, '0);
    wait_valid(n);
    chk("b2b.lat1", n, LAT);
    chk("b2b.out1", bus.sample_out, 176);
    strobe();                                 // sampled while out_valid=1
    chk("b2b.busy", bus.busy, 1);
    chk("b2b.vld_lo", bus.out_valid, 0);
    chk("b2b.ovr", bus.overrun, 0);
    wait_valid(n);
    chk("b2b.lat2", n, LAT);
    chk("b2b.out2", bus.sample_out, 0);
    chk("b2b.cnt2", bus.active_count, 0);
    @(posedge clk); #1;
    chk("b2b.vld_end", bus.out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/signal_mixer_seq.md
# signal_mixer_seq

Time-multiplexed, parametrised audio mixer that sums NUM_CH unsigned samples with per-channel gain into one output sample. It sits between the per-voice sample generators and the PWM/DAC output stage. Each sample-rate strobe triggers one mix, one channel per clock through a single multiply-accumulate. The output stage wraps or saturates, selected at run time. With unity gains, OUT_SHIFT=0 and wrap mode, the result equals the enabled-sample sum modulo 2^SAMPLE_W.

## Interface
- NUM_CH, 12, number of input channels (≥2)
- SAMPLE_W, 8, input/output sample width, unsigned
- GAIN_W, 4, per-channel gain width; unity gain = 2^(GAIN_W-1)
- OUT_SHIFT, 0, extra right shift applied to the final sum (attenuation)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sample_strobe  in  1  one-cycle pulse starting a mix
- samples_in  in  NUM_CH×SAMPLE_W  packed channel samples, channel i at [i*SAMPLE_W +: SAMPLE_W]
- sample_enable  in  NUM_CH  per-channel enable
- gain  in  NUM_CH×GAIN_W  packed per-channel gain
- saturate  in  1  1 = clamp output, 0 = wrap (truncate)
- clear_overrun  in  1  clears overrun flag
- sample_out  out  SAMPLE_W  mixed sample, held until next result
- out_valid  out  1  one-cycle pulse, sample_out updated
- busy  out  1  mix in progress
- active_count  out  $clog2(NUM_CH+1)  enabled channels in last completed mix
- overrun  out  1  sticky: strobe arrived while busy

## Operation
- Accumulator width ACC_W = SAMPLE_W + GAIN_W + $clog2(NUM_CH), unsigned; it never overflows.
- FSM states: IDLE, ACCUM, DONE.
- IDLE, strobe=1:
  - latch samples_in, sample_enable, gain and saturate into shadow registers.
  - acc←0, idx←0, cnt←0.
  - go to ACCUM.
- ACCUM, one channel per cycle:
  - if shadow enable[idx]=1: acc += sample[idx]*gain[idx] (full-width product), cnt++.
  - idx++.
  - after idx=NUM_CH-1 is processed: go to DONE.
- DONE:
  - r = acc >> (GAIN_W-1+OUT_SHIFT).
  - wrap: sample_out←r[SAMPLE_W-1:0].
  - saturate: sample_out←(r > 2^SAMPLE_W-1) ? all-ones : r[SAMPLE_W-1:0].
  - active_count←cnt, out_valid←1, go to IDLE.
- Inputs changing during a mix have no effect; only the latched copies are used.
- busy = (state ≠ IDLE).
- Strobe while busy: ignored, the mix in progress is unaffected, overrun←1.
- clear_overrun=1 clears overrun. If an overrun event and clear_overrun occur in the same cycle, set wins.
- No channels enabled: sample_out=0, active_count=0, out_valid still pulses.

## Timing
- Reset values:
  - state IDLE; acc, idx, cnt = 0.
  - sample_out=0, out_valid=0, busy=0, active_count=0, overrun=0.
- Latency, with strobe sampled at edge E:
  - busy is high from after E until after edge E+NUM_CH+1.
  - out_valid and the new sample_out are visible after edge E+NUM_CH+1, for exactly one cycle (out_valid).
- Throughput: one mix per NUM_CH+2 cycles.
  - A strobe in the cycle where out_valid=1 is accepted (state is IDLE), so back-to-back mixes are possible.
- Reset mid-mix: the mix is aborted, with no out_valid. All outputs return to reset values after the reset edge.
- out_valid is never high for two consecutive cycles.

## Test plan
- Default params, all 12 enabled, all samples 20, gains 8, wrap: strobe → after 13 edges sample_out=240, active_count=12, out_valid high 1 cycle, busy low the next cycle.
- All samples 100, all enabled, gains 8:
  - wrap → sample_out=176 (1200 mod 256).
  - repeat with saturate=1 → sample_out=255.
- Gain: only ch0 enabled.
  - sample 200, gain 4 → 100.
  - then sample 100, gain 15 → 187 (1500>>3).
  - all other channels at 255 with enable=0 must not contribute.
- Overrun:
  - strobe again 3 cycles after the first → ignored, first result unchanged, overrun=1.
  - clear_overrun → 0.
  - clear_overrun and an ignored strobe in the same cycle → overrun stays 1.
- Reset at the 5th ACCUM cycle → busy=0, sample_out=0, no out_valid. A following strobe yields a correct full mix.
- No enables, plus a strobe in the out_valid cycle of a previous mix → both accepted; second mix gives sample_out=0, active_count=0, out_valid pulse.
